// File: rtl/sump_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// sump_cmd_sequencer
//
// Command front-end of the logic sniffer. Sits between the UART receiver /
// transmitter and the capture core.
//
//   * Parses the SUMP byte stream into short commands (bit7 = 0, one byte)
//     and long commands (bit7 = 1, opcode followed by four data bytes).
//   * Short commands become single-cycle control pulses:
//       0x00 -> cmd_reset, 0x01 -> cmd_arm, 0x02 -> ID reply, 0x04 -> cmd_meta.
//     Every other short opcode is ignored.
//   * Long commands become a register-write strobe (wr_strobe/wr_addr/wr_data).
//   * ID queries are answered locally with the 4-byte string "1ALS" through
//     the valid/ready transmitter handshake.
//   * A long command that stalls for TIMEOUT_CYCLES idle clocks is dropped
//     and frame_err pulses.
//
// Every command output is registered and appears exactly one clock after the
// rx_valid cycle of the command's final byte.
//
// Build option:
//   CMD_RESET_FILTER_EN  When defined, cmd_reset fires only on the 5th
//                        consecutive short 0x00; any other received byte
//                        restarts the run. When undefined, every short 0x00
//                        fires cmd_reset.
//
// Parameters:
//   TIMEOUT_CYCLES  idle clocks tolerated between bytes of a long command
//   TO_W            timeout counter width, 2**TO_W must exceed TIMEOUT_CYCLES
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   rx_data    in   received byte, qualified by rx_valid
//   rx_valid   in   one-cycle strobe per received byte, no backpressure
//   tx_data    out  byte to transmit
//   tx_valid   out  tx_data valid, held until accepted
//   tx_ready   in   transmitter accepts when tx_valid && tx_ready
//   cmd_reset  out  pulse: reset capture core
//   cmd_arm    out  pulse: arm capture
//   cmd_meta   out  pulse: metadata request
//   wr_strobe  out  pulse: long-command register write
//   wr_addr    out  long opcode of the most recent write
//   wr_data    out  long data of the most recent write, first byte in [31:24]
//   frame_err  out  pulse: partial long command discarded on timeout
//   busy       out  long command being assembled or ID reply in progress
// ---------------------------------------------------------------------------
module sump_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        cmd_reset,
    output logic        cmd_arm,
    output logic        cmd_meta,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        frame_err,
    output logic        busy
);

    // Receive FSM states
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] LONG    = 1'b1;

    // Transmit FSM states
    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;

    // Last counter value before the timeout fires. The counter is cleared on
    // the edge that accepts a byte, so firing at TIMEOUT_CYCLES-1 puts
    // frame_err exactly TIMEOUT_CYCLES clocks after that byte's edge.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Short opcodes
    localparam logic [7:0] OP_RESET = 8'h00;
    localparam logic [7:0] OP_ARM   = 8'h01;
    localparam logic [7:0] OP_ID    = 8'h02;
    localparam logic [7:0] OP_META  = 8'h04;

    logic [0:0]      rx_state;
    logic [0:0]      tx_state;
    logic [7:0]      long_op;    // opcode of the long command being assembled
    logic [23:0]     data_sr;    // first three data bytes; the 4th goes straight out
    logic [1:0]      byte_cnt;   // data bytes received so far in LONG
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      tx_idx;     // index of the reply byte currently on tx_data

    // Short-command decode, valid only in the cycle the byte is presented
    logic short_hit;
    logic dec_reset;
    logic dec_arm;
    logic dec_meta;
    logic dec_id;
    logic reset_hit;             // dec_reset after the optional run filter

    // -----------------------------------------------------------------------
    // ID reply table
    // -----------------------------------------------------------------------
    // NOTE: the reply is a constant lookup, not storage, so there is nothing
    // here that needs a reset value; only tx_idx, which selects it, is reset.
    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = 8'h31;   // '1'
            2'd1:    id_byte = 8'h41;   // 'A'
            2'd2:    id_byte = 8'h4C;   // 'L'
            default: id_byte = 8'h53;   // 'S'
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Short-command decode
    // -----------------------------------------------------------------------
    assign short_hit = rx_valid && (rx_state == IDLE) && !rx_data[7];

    // NOTE: every output of this block gets a default before the case, so
    // opcodes without an arm cannot leave a value held and infer a latch.
    always_comb begin
        dec_reset = 1'b0;
        dec_arm   = 1'b0;
        dec_meta  = 1'b0;
        dec_id    = 1'b0;
        if (short_hit) begin
            case (rx_data)
                OP_RESET: dec_reset = 1'b1;
                OP_ARM:   dec_arm   = 1'b1;
                OP_ID:    dec_id    = 1'b1;
                OP_META:  dec_meta  = 1'b1;
                default:  ;   // unknown short opcodes are dropped silently
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Optional cmd_reset run filter
    // -----------------------------------------------------------------------
`ifdef CMD_RESET_FILTER_EN
    // Count consecutive short 0x00 bytes. Only received bytes touch the
    // counter, so a long-command timeout leaves it untouched.
    logic [2:0] zero_run;

    always_ff @(posedge clock) begin
        if (reset) begin
            zero_run <= 3'd0;
        end else if (rx_valid) begin
            if (dec_reset) begin
                if (zero_run == 3'd4) begin
                    zero_run <= 3'd0;
                end else begin
                    zero_run <= zero_run + 3'd1;
                end
            end else begin
                zero_run <= 3'd0;
            end
        end
    end

    assign reset_hit = dec_reset && (zero_run == 3'd4);
`else
    assign reset_hit = dec_reset;
`endif

    // -----------------------------------------------------------------------
    // Receive FSM: short pulses, long-command assembly, timeout
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples pre-edge values, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state  <= IDLE;
            long_op   <= 8'h00;
            data_sr   <= 24'h0;
            byte_cnt  <= 2'd0;
            to_cnt    <= '0;
            cmd_reset <= 1'b0;
            cmd_arm   <= 1'b0;
            cmd_meta  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 32'h0;
            frame_err <= 1'b0;
        end else begin
            // Pulses default low and are raised for exactly one cycle below.
            cmd_reset <= reset_hit;
            cmd_arm   <= dec_arm;
            cmd_meta  <= dec_meta;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;

            case (rx_state)
                IDLE: begin
                    if (rx_valid && rx_data[7]) begin
                        long_op  <= rx_data;
                        data_sr  <= 24'h0;
                        byte_cnt <= 2'd0;
                        to_cnt   <= '0;
                        rx_state <= LONG;
                    end
                end

                LONG: begin
                    // A byte arriving on the timeout cycle is checked first,
                    // so it is accepted and the timeout never fires.
                    if (rx_valid) begin
                        data_sr  <= {data_sr[15:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        to_cnt   <= '0;
                        if (byte_cnt == 2'd3) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= long_op;
                            wr_data   <= {data_sr, rx_data};
                            rx_state  <= IDLE;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        frame_err <= 1'b1;
                        to_cnt    <= '0;
                        rx_state  <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                default: rx_state <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Transmit FSM: ID reply over the valid/ready handshake
    // -----------------------------------------------------------------------
    // A query arriving while a reply is in flight is dropped, not queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            tx_idx   <= 2'd0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (dec_id) begin
                        tx_state <= TX_SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= id_byte(2'd0);
                        tx_idx   <= 2'd0;
                    end
                end

                TX_SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (tx_idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            tx_idx   <= 2'd0;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_idx  <= tx_idx + 2'd1;
                            tx_data <= id_byte(tx_idx + 2'd1);
                        end
                    end
                end

                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign busy = (rx_state != IDLE) || (tx_state != TX_IDLE);

endmodule

// File: doc/sump_cmd_sequencer.md
Name: sump_cmd_sequencer

Overview:
- Command front-end of the logic sniffer, between the UART receiver/transmitter and the capture core.
- Parses the SUMP byte stream from the UART receiver into short commands (opcode bit7 = 0, 1 byte) and long commands (opcode bit7 = 1, opcode + 4 data bytes).
- Short commands become single-cycle control pulses (reset, arm, metadata).
- Long commands become register-write strobes into the capture core configuration.
- Answers ID queries itself by sequencing a 4-byte reply through the UART transmitter handshake.

Parameters:
- TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of a long command before the partial command is discarded (10 ms at 100 MHz).
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte; no backpressure.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter can accept; a transfer happens when tx_valid && tx_ready.
- cmd_reset  out  1  one-cycle pulse: reset the capture core.
- cmd_arm  out  1  one-cycle pulse: arm (opcode 0x01).
- cmd_meta  out  1  one-cycle pulse: metadata request (opcode 0x04).
- wr_strobe  out  1  one-cycle pulse: long-command register write.
- wr_addr  out  8  long opcode; held stable after wr_strobe until the next write.
- wr_data  out  32  long data; first data byte received in [31:24], last in [7:0].
- frame_err  out  1  one-cycle pulse when a partial long command is discarded on timeout.
- busy  out  1  high while a long command is being assembled or an ID reply is in progress.

Behaviour:
- Reset values: all pulse outputs 0; tx_valid 0; tx_data 0x00; wr_addr 0x00; wr_data 0; busy 0; receive FSM in IDLE; transmit FSM in TX_IDLE; counters 0.
- Reset while assembling a long command or sending an ID reply aborts immediately. No write and no further tx bytes occur.
- Receive FSM, IDLE:
  - rx_valid with bit7 = 1: latch opcode, clear data shift register and byte count, go to LONG.
  - rx_valid with bit7 = 0: decode as a short command and stay in IDLE.
  - 0x00 gives cmd_reset, 0x01 gives cmd_arm, 0x02 starts an ID reply, 0x04 gives cmd_meta.
  - All other short opcodes are ignored silently.
- Receive FSM, LONG:
  - Each rx_valid shifts the byte in as data = {data[23:0], rx_data} and increments the count.
  - On the 4th byte: wr_addr/wr_data update and wr_strobe pulses, all on the cycle after that rx_valid. FSM returns to IDLE.
  - Bytes received in LONG are always data, even if their value looks like an opcode.
- Latency: every command output (pulse or write) appears exactly 1 clock after the rx_valid cycle of its final byte.
- Timeout:
  - Counter clears on entry to LONG and on each rx_valid; it increments while in LONG.
  - Reaching TIMEOUT_CYCLES returns the FSM to IDLE and pulses frame_err for 1 cycle. No wr_strobe is issued.
  - If rx_valid arrives on the same cycle the timeout fires, the byte wins: it is accepted and the timeout is cancelled.
- ID reply:
  - Opcode 0x02 in IDLE, while TX_IDLE, enters TX_SEND. The reply is 0x31, 0x41, 0x4C, 0x53 ("1ALS") in that order.
  - tx_valid rises 1 clock after the 0x02 rx_valid.
  - tx_data advances on each accepted transfer. After the 4th transfer, tx_valid drops on the next edge and the FSM returns to TX_IDLE.
  - A 0x02 received while in TX_SEND is dropped; no queuing.
  - The receive FSM keeps operating during TX_SEND, so commands may overlap a reply.
- busy = (receive FSM != IDLE) || (transmit FSM != TX_IDLE).

Optional Feature:
- Macro: CMD_RESET_FILTER_EN.
- When defined:
  - cmd_reset pulses only on the 5th consecutive short 0x00; the run counter then clears.
  - Any other byte clears the run counter, so 4 × 0x00 followed by 0x01 gives only cmd_arm.
  - Timeout does not clear the counter.
- When undefined: every 0x00 in IDLE pulses cmd_reset and no run counter exists.

Test Plan:
- Reset, then bytes 0x02, 0x04, each 1 µs apart, tx_ready tied high:
  - tx_data sequence 0x31, 0x41, 0x4C, 0x53 with exactly 4 transfers.
  - cmd_meta pulses once.
- Long write 0xC2 00 00 00 08 -> wr_strobe once, wr_addr = 0xC2, wr_data = 0x00000008, 1 clock after the last byte; busy low afterwards.
- Long write 0x81 FF 00 FF 00, then short 0x01 -> wr_data = 0xFF00FF00, then cmd_arm 1 clock after the 0x01 byte.
- Send 0xC0 plus 2 data bytes, then silence; TIMEOUT_CYCLES = 100 for this test:
  - frame_err pulses 100 clocks after the last byte; no wr_strobe.
  - A subsequent 0x01 gives cmd_arm.
- ID reply with tx_ready held low for 50 clocks, a second 0x02 sent meanwhile, and reset asserted mid-reply in a second run:
  - tx_valid held high and tx_data stable at 0x31 while tx_ready is low.
  - The second 0x02 is ignored.
  - After reset: tx_valid = 0 and no further transfers.
- Filter behaviour:
  - With CMD_RESET_FILTER_EN: 5 × 0x00 -> single cmd_reset on the 5th; 4 × 0x00 + 0x02 -> no cmd_reset.
  - Without CMD_RESET_FILTER_EN: 5 × 0x00 -> 5 cmd_reset pulses.
